// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
// Optional feature macro: PS2_PARITY_CHECK_EN (see rtl/ps2.sv).
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEF_FILTER_LEN = 8;
   localparam int DEF_TIMEOUT    = 12500;   // 250 us at 50 MHz

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one raw PS/2 line.
// The output follows the synchronized line only after FILTER_LEN equal samples.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filtered
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments only; the synchronous
   // reset loads the idle-high level so no false edge appears after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 2'b11;
         filtered <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
         if (sync_q[1] == filtered) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filtered <= sync_q[1];
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2.sv
// PS/2 device-to-host receiver: filtered edge detect, 11-bit deframer, watchdog.
// Define PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
module ps2
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic       valid,
   output logic [7:0] code
);

   localparam int BIT_W = $clog2(DATA_BITS);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   logic clk_f;
   logic data_f;
   logic clk_f_q;
   logic fall;

   ps2_state_e state_q, state_next;

   logic [DATA_BITS-1:0] shift_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [WD_W-1:0]      wd_q;
   logic                 wd_expired;
   logic                 start_en;
   logic                 shift_en;
   logic                 accept;
   logic                 parity_ok;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk      (clk),
      .rst      (rst),
      .raw      (ps2Clk),
      .filtered (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk      (clk),
      .rst      (rst),
      .raw      (ps2Data),
      .filtered (data_f)
   );

   assign fall       = clk_f_q & ~clk_f;
   assign wd_expired = (wd_q == WD_W'(TIMEOUT));

`ifdef PS2_PARITY_CHECK_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (fall && state_q == PARITY) begin
         par_q <= data_f;
      end
   end

   assign parity_ok = ^{shift_q, par_q};
`else
   // The parity bit is clocked through the PARITY state but not stored.
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_next;
   end

   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      state_next = state_q;
      start_en   = 1'b0;
      shift_en   = 1'b0;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall && data_f == START_BIT) begin
               start_en   = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               shift_en = 1'b1;
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_next = PARITY;
            end
         end
         PARITY: begin
            if (fall) state_next = STOP;
         end
         STOP: begin
            if (fall) begin
               accept     = (data_f == STOP_BIT) && parity_ok;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // A falling edge in the same cycle beats the watchdog.
      if (!fall && wd_expired && state_q != IDLE) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_f_q   <= 1'b1;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         wd_q      <= '0;
         code      <= 8'h00;
         valid     <= 1'b0;
      end else begin
         clk_f_q <= clk_f;
         valid   <= accept;
         if (accept) code <= shift_q;

         if (start_en) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
         end else if (shift_en) begin
            shift_q   <= {data_f, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end

         if (fall || state_q == IDLE) wd_q <= '0;
         else if (!wd_expired)        wd_q <= wd_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2.sv
// Directed bench for ps2: make/break, parity, framing, timeout and reset cases.
// Bit period is scaled to 100 system clocks so the run stays short.
module tb_ps2;

   localparam int FL = 8;
   localparam int TO = 300;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       valid;
   logic [7:0] code;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int wide   = 0;
   int stray  = 0;
   int lat    = 0;
   int p0;

   logic       prev_valid = 1'b0;
   logic [7:0] prev_code  = 8'h00;

   always #10 clk = ~clk;

   ps2 #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .ps2Clk  (ps2_clk),
      .ps2Data (ps2_data),
      .valid   (valid),
      .code    (code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse counter, pulse-width and stray-code monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (valid) begin
         pulses++;
         if (prev_valid) wide++;
      end else if (!rst && code !== prev_code) begin
         stray++;
      end
      prev_valid = valid;
      prev_code  = code;
   end

   // One PS/2 bit: data set 10 clocks before the falling edge, 50 low, 40 high.
   task automatic drive_bit(input logic b, input bit last);
      ps2_data = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      if (last) begin
         lat = 0;
         for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (valid && lat == 0) lat = k;
         end
      end else begin
         repeat (50) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
      logic [10:0] f;
      f = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) drive_bit(f[i], i == 10);
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      repeat (4) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_code", code, 8'h00);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Make code 0x75: five ones, parity 0
      p0 = pulses;
      send_frame(8'h75, 1'b0, 1'b1, 11);
      check("make_pulses", pulses - p0, 1);
      check("make_code", code, 8'h75);
      check("make_latency", lat, 2 + FL + 1);

      // Break sequence F0 then 75
      p0 = pulses;
      send_frame(8'hF0, 1'b1, 1'b1, 11);
      check("brk_f0_code", code, 8'hF0);
      send_frame(8'h75, 1'b0, 1'b1, 11);
      check("brk_pulses", pulses - p0, 2);
      check("brk_75_code", code, 8'h75);

      // Framing error, then good 0x1C
      p0 = pulses;
      send_frame(8'h29, 1'b0, 1'b0, 11);
      check("frame_err_pulses", pulses - p0, 0);
      check("frame_err_code", code, 8'h75);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("after_frame_err_pulses", pulses - p0, 1);
      check("after_frame_err_code", code, 8'h1C);

      // 0x75 with wrong parity bit 1
      p0 = pulses;
      send_frame(8'h75, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
      check("bad_par_pulses", pulses - p0, 0);
      check("bad_par_code", code, 8'h1C);
`else
      check("bad_par_pulses", pulses - p0, 1);
      check("bad_par_code", code, 8'h75);
`endif

      // Falling edge with data high in IDLE is not a start bit
      p0 = pulses;
      drive_bit(1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b1, 11);
      check("idle_high_pulses", pulses - p0, 1);
      check("idle_high_code", code, 8'hF0);

      // Abort after 4 data bits, idle past the watchdog, then 0x29
      p0 = pulses;
      send_frame(8'h75, 1'b0, 1'b1, 5);
      repeat (400) @(negedge clk);
      send_frame(8'h29, 1'b0, 1'b1, 11);
      check("timeout_pulses", pulses - p0, 1);
      check("timeout_code", code, 8'h29);

      // Reset after 5 bits, then 0x75
      send_frame(8'h75, 1'b0, 1'b1, 5);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_code", code, 8'h00);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      p0 = pulses;
      send_frame(8'h75, 1'b0, 1'b1, 11);
      check("post_rst_pulses", pulses - p0, 1);
      check("post_rst_code", code, 8'h75);

      check("valid_width", wide, 0);
      check("code_without_valid", stray, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
